present_encrypt_ctrl: RTL and testbench

PRESENT_ENCRYPT_CTRL -- requirements
Module: present_encrypt_ctrl

---
 rtl/present_encrypt_ctrl_if.sv | 33 +++
 rtl/present_encrypt_ctrl.sv | 139 +++++++++++++
 tb/tb_present_encrypt_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/present_encrypt_ctrl_if.sv
// Requester handshake and encryptor-core bus of the PRESENT encryption controller.
// The slave modport is the controller; the master modport is the requester/core side.
interface present_encrypt_ctrl_if;
  localparam int unsigned KEY_W = 80;
  localparam int unsigned BLK_W = 64;

  logic [KEY_W-1:0] key_i;
  logic             key_valid_i;
  logic             key_ready_o;
  logic [BLK_W-1:0] pt_i;
  logic             pt_valid_i;
  logic             pt_ready_o;
  logic [BLK_W-1:0] ct_o;
  logic             ct_valid_o;
  logic             ct_ready_i;
  logic             busy_o;
  logic [KEY_W-1:0] core_data_o;
  logic             core_key_load_o;
  logic             core_data_load_o;
  logic [BLK_W-1:0] core_data_i;

  modport slave (
    input  key_i, key_valid_i, pt_i, pt_valid_i, ct_ready_i, core_data_i,
    output key_ready_o, pt_ready_o, ct_o, ct_valid_o, busy_o,
           core_data_o, core_key_load_o, core_data_load_o
  );

  modport master (
    output key_i, key_valid_i, pt_i, pt_valid_i, ct_ready_i, core_data_i,
    input  key_ready_o, pt_ready_o, ct_o, ct_valid_o, busy_o,
           core_data_o, core_key_load_o, core_data_load_o
  );
endinterface

// File: rtl/present_encrypt_ctrl.sv
// Sequences one PRESENT-80 encryption per plaintext: reloads the key, loads the block,
// waits a fixed core latency, then holds the ciphertext until the requester takes it.
module present_encrypt_ctrl #(
  parameter int unsigned LATENCY = 33
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  present_encrypt_ctrl_if.slave bus
);
  localparam int unsigned KEY_W = 80;
  localparam int unsigned BLK_W = 64;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned PAD_W = KEY_W - BLK_W;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KEY = 3'd1,
    LOAD_PT  = 3'd2,
    RUN      = 3'd3,
    OUT      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_vld_q, key_vld_d;
  logic [BLK_W-1:0] pt_q, pt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0] ct_q, ct_d;
  logic             ct_valid_q, ct_valid_d;
  logic             busy_q, busy_d;
  logic             key_ready_q, key_ready_d;
  logic [KEY_W-1:0] core_data_q, core_data_d;
  logic             key_load_q, key_load_d;
  logic             data_load_q, data_load_d;
  logic             key_hs, pt_hs;

  // A key offered alongside the plaintext makes the plaintext acceptable in the same cycle.
  assign bus.pt_ready_o       = key_ready_q & (key_vld_q | bus.key_valid_i);
  assign bus.key_ready_o      = key_ready_q;
  assign bus.ct_o             = ct_q;
  assign bus.ct_valid_o       = ct_valid_q;
  assign bus.busy_o           = busy_q;
  assign bus.core_data_o      = core_data_q;
  assign bus.core_key_load_o  = key_load_q;
  assign bus.core_data_load_o = data_load_q;

  assign key_hs = bus.key_valid_i & key_ready_q;
  assign pt_hs  = bus.pt_valid_i & bus.pt_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      key_q       <= '0;
      key_vld_q   <= 1'b0;
      pt_q        <= '0;
      cnt_q       <= '0;
      ct_q        <= '0;
      ct_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      key_ready_q <= 1'b1;
      core_data_q <= '0;
      key_load_q  <= 1'b0;
      data_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_vld_q   <= key_vld_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      ct_q        <= ct_d;
      ct_valid_q  <= ct_valid_d;
      busy_q      <= busy_d;
      key_ready_q <= key_ready_d;
      core_data_q <= core_data_d;
      key_load_q  <= key_load_d;
      data_load_q <= data_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    key_vld_d   = key_vld_q;
    pt_d        = pt_q;
    cnt_d       = cnt_q;
    ct_d        = ct_q;
    core_data_d = '0;
    key_load_d  = 1'b0;
    data_load_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_hs) begin
          key_d     = bus.key_i;
          key_vld_d = 1'b1;
        end
        if (pt_hs) begin
          pt_d    = bus.pt_i;
          state_d = LOAD_KEY;
        end
      end
      LOAD_KEY: state_d = LOAD_PT;
      LOAD_PT: begin
        cnt_d   = CNT_W'(1);
        state_d = RUN;
      end
      RUN: begin
        if (cnt_q == LAT_CNT) begin
          ct_d    = bus.core_data_i;
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      OUT: begin
        if (bus.ct_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_d)
      LOAD_KEY: begin
        core_data_d = key_d;
        key_load_d  = 1'b1;
      end
      LOAD_PT: begin
        core_data_d = {PAD_W'(0), pt_d};
        data_load_d = 1'b1;
      end
      default: ;
    endcase
    busy_d      = (state_d != IDLE);
    ct_valid_d  = (state_d == OUT);
    key_ready_d = (state_d == IDLE);
  end
endmodule

// File: tb/tb_present_encrypt_ctrl.sv
// Bench for present_encrypt_ctrl with a behavioural PRESENT-80 core driving core_data_i
// only in the exact cycle the ciphertext is due, and junk otherwise.
module tb_present_encrypt_ctrl;
  localparam int unsigned LAT = 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  present_encrypt_ctrl_if bus();

  present_encrypt_ctrl #(.LATENCY(LAT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Core model: clobbers its key after each block, like the real round-key update.
  logic [79:0] core_key       = '0;
  logic [63:0] core_ct        = '0;
  logic [63:0] core_junk      = '0;
  int          core_cnt       = 1000;
  logic        core_key_fresh = 1'b0;
  int          reload_miss    = 0;
  int          overlap        = 0;

  assign bus.core_data_i = (core_cnt == int'(LAT)) ? core_ct : core_junk;

  always @(posedge clk) begin
    core_junk <= {$urandom, $urandom};
    if (bus.core_key_load_o) begin
      core_key       <= bus.core_data_o;
      core_key_fresh <= 1'b1;
    end
    if (bus.core_data_load_o) begin
      if (!core_key_fresh) reload_miss++;
      core_ct        <= present80(core_key, bus.core_data_o[63:0]);
      core_key       <= ~core_key;
      core_key_fresh <= 1'b0;
      core_cnt       <= 1;
    end else if (core_cnt < 1000) begin
      core_cnt <= core_cnt + 1;
    end
  end

  always @(negedge clk) if (bus.core_key_load_o && bus.core_data_load_o) overlap++;

  logic [79:0] tb_key     = '0;
  logic        tb_key_vld = 1'b0;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [79:0] k);
    bus.key_valid_i = 1'b1;
    bus.key_i       = k;
    #1;
    chk("key_ready_idle", 80'(bus.key_ready_o), 80'(1'b1));
    tick();
    bus.key_valid_i = 1'b0;
    tb_key          = k;
    tb_key_vld      = 1'b1;
    chk("busy_after_key", 80'(bus.busy_o), 80'(1'b0));
  endtask

  task automatic encrypt(input logic kv, input logic [79:0] k, input logic [63:0] p,
                         input int rdly, input logic use_known, input logic [63:0] known);
    logic [63:0] exp;
    int          c;
    bus.key_valid_i = kv;
    bus.key_i       = k;
    bus.pt_valid_i  = 1'b1;
    bus.pt_i        = p;
    #1;
    chk("pt_ready_idle", 80'(bus.pt_ready_o), 80'(1'b1));
    if (kv) tb_key = k;
    tb_key_vld = 1'b1;
    exp = use_known ? known : present80(tb_key, p);
    tick();
    bus.key_valid_i = 1'b0;
    bus.pt_valid_i  = 1'b0;
    chk("load_key_strobes", 80'({bus.core_key_load_o, bus.core_data_load_o}), 80'(2'b10));
    chk("load_key_data", bus.core_data_o, tb_key);
    chk("busy_load", 80'(bus.busy_o), 80'(1'b1));
    tick();
    chk("load_pt_strobes", 80'({bus.core_key_load_o, bus.core_data_load_o}), 80'(2'b01));
    chk("load_pt_data", bus.core_data_o, {16'h0000, p});
    c = 2;
    while (!bus.ct_valid_o && c < 200) begin
      tick();
      c++;
    end
    chk("latency", 80'(c), 80'(LAT + 3));
    chk("ct_value", 80'(bus.ct_o), 80'(exp));
    for (int i = 0; i < rdly; i++) begin
      bus.key_valid_i = 1'b1;
      bus.key_i       = {$urandom, $urandom, $urandom};
      bus.pt_valid_i  = 1'b1;
      bus.pt_i        = {$urandom, $urandom};
      #1;
      chk("out_key_ready", 80'(bus.key_ready_o), 80'(1'b0));
      chk("out_pt_ready", 80'(bus.pt_ready_o), 80'(1'b0));
      tick();
      chk("out_valid_hold", 80'(bus.ct_valid_o), 80'(1'b1));
      chk("out_ct_hold", 80'(bus.ct_o), 80'(exp));
    end
    bus.key_valid_i = 1'b0;
    bus.pt_valid_i  = 1'b0;
    bus.ct_ready_i  = 1'b1;
    tick();
    bus.ct_ready_i = 1'b0;
    chk("idle_valid", 80'(bus.ct_valid_o), 80'(1'b0));
    chk("idle_busy", 80'(bus.busy_o), 80'(1'b0));
    chk("idle_key_ready", 80'(bus.key_ready_o), 80'(1'b1));
    chk("ct_retained", 80'(bus.ct_o), 80'(exp));
  endtask

  initial begin
    int seen;
    bus.key_i       = '0;
    bus.key_valid_i = 1'b0;
    bus.pt_i        = '0;
    bus.pt_valid_i  = 1'b0;
    bus.ct_ready_i  = 1'b0;

    // Reset values, then a plaintext with no key loaded must be refused.
    #3;
    chk("rst_ct", 80'(bus.ct_o), 80'(0));
    chk("rst_ct_valid", 80'(bus.ct_valid_o), 80'(0));
    chk("rst_busy", 80'(bus.busy_o), 80'(0));
    chk("rst_core_data", bus.core_data_o, 80'(0));
    #20;
    rst_n = 1'b1;
    tick();
    bus.pt_valid_i = 1'b1;
    bus.pt_i       = 64'h0123456789ABCDEF;
    #1;
    chk("nokey_key_ready", 80'(bus.key_ready_o), 80'(1'b1));
    chk("nokey_pt_ready", 80'(bus.pt_ready_o), 80'(1'b0));
    tick();
    tick();
    chk("nokey_busy", 80'(bus.busy_o), 80'(1'b0));
    chk("nokey_strobes", 80'({bus.core_key_load_o, bus.core_data_load_o}), 80'(2'b00));
    bus.pt_valid_i = 1'b0;

    // Known-answer vectors.
    load_key(80'h0);
    encrypt(1'b0, 80'h0, 64'h0, 0, 1'b1, 64'h5579C1387B228445);
    load_key({80{1'b1}});
    encrypt(1'b0, 80'h0, 64'h0, 1, 1'b1, 64'hE72C46C0F5945049);
    encrypt(1'b0, 80'h0, {64{1'b1}}, 0, 1'b1, 64'h3333DCD3213210D2);
    encrypt(1'b1, 80'h0, {64{1'b1}}, 10, 1'b1, 64'hA112FFC72F68417B);

    // Random traffic against the reference model.
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) load_key({$urandom, $urandom, $urandom});
      encrypt(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, 3)), 1'b0, 64'h0);
    end

    // Reset in the middle of RUN abandons the block and forgets the key.
    bus.pt_valid_i = 1'b1;
    bus.pt_i       = {$urandom, $urandom};
    tick();
    bus.pt_valid_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("midrun_busy", 80'(bus.busy_o), 80'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ct", 80'(bus.ct_o), 80'(0));
    chk("midrst_ct_valid", 80'(bus.ct_valid_o), 80'(0));
    chk("midrst_busy", 80'(bus.busy_o), 80'(0));
    chk("midrst_core_data", bus.core_data_o, 80'(0));
    chk("midrst_strobes", 80'({bus.core_key_load_o, bus.core_data_load_o}), 80'(2'b00));
    #1;
    rst_n = 1'b1;
    tick();
    bus.pt_valid_i = 1'b1;
    #1;
    chk("postrst_key_ready", 80'(bus.key_ready_o), 80'(1'b1));
    chk("postrst_pt_ready", 80'(bus.pt_ready_o), 80'(1'b0));
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.ct_valid_o || bus.busy_o) seen++;
    end
    bus.pt_valid_i = 1'b0;
    chk("postrst_no_activity", 80'(seen), 80'(0));

    chk("strobe_overlap", 80'(overlap), 80'(0));
    chk("key_reload_each_block", 80'(reload_miss), 80'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
